// File: rtl/dbus_uart_pkg.sv
// Shared definitions for the data-bus UART: register offsets, STATUS bit
// positions and the TX/RX state encodings.
package dbus_uart_pkg;

    // Register offsets, selected by daddr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_FIFO_FULL  = 1;
    localparam int ST_FIFO_EMPTY = 2;
    localparam int ST_RX_VALID   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_FERR    = 5;
    localparam int ST_RX_OVR     = 6;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/dbus_uart_fifo.sv
// Synchronous show-ahead FIFO for the transmit path. A push while full is
// dropped even if a pop happens in the same cycle (fullness is judged on the
// state before the edge).
module dbus_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_uart.sv
// Memory-mapped 8N1 UART on the CPU data port: TX FIFO + transmitter,
// single-byte receive holding register, one-cycle registered read data.
module dbus_uart
    import dbus_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter logic [31:0] BASE_ADDR  = 32'h1FD0_F000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    // Bus decode
    logic        w_sel, w_rd, w_wr0, w_push_req, w_st_clr, w_rx_rd;
    logic [1:0]  w_reg;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    // FIFO interface
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full, w_fifo_empty, w_tx_pop;

    // Transmitter
    tx_state_t   r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;

    // Receiver
    rx_state_t   r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        r_rx_s1, r_rx_s2, r_rx_d;
    logic        w_rxs, w_rx_fall, w_rx_byte_ok, w_rx_frame_bad;

    // Registers visible through STATUS / RXDATA
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_tx_ovf, r_rx_ferr, r_rx_ovr;
    logic [31:0] r_dm;

    assign w_sel      = dce && (daddr[31:4] == BASE_ADDR[31:4]);
    assign w_reg      = daddr[3:2];
    assign w_rd       = w_sel && (we == 4'b0000);
    assign w_wr0      = w_sel && we[0];
    assign w_push_req = w_wr0 && (w_reg == REG_TXDATA);
    assign w_st_clr   = w_wr0 && (w_reg == REG_STATUS);
    assign w_rx_rd    = w_rd && (w_reg == REG_RXDATA);
    assign w_unused   = ^{daddr[1:0], din[31:8]};

    assign w_rxs      = r_rx_s2;
    assign w_rx_fall  = r_rx_d && !r_rx_s2;

    assign dm       = r_dm;
    assign irq      = r_rx_valid;
    assign uart_txd = (r_tx_state == TX_START) ? 1'b0 :
                      (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

    dbus_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (cpu_clk_50M),
        .i_rst   (cpu_rst),
        .i_push  (w_push_req),
        .i_din   (din[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // STATUS word assembly
    always_comb begin
        w_status                = '0;
        w_status[ST_TX_BUSY]    = (r_tx_state != TX_IDLE);
        w_status[ST_FIFO_FULL]  = w_fifo_full;
        w_status[ST_FIFO_EMPTY] = w_fifo_empty;
        w_status[ST_RX_VALID]   = r_rx_valid;
        w_status[ST_TX_OVF]     = r_tx_ovf;
        w_status[ST_RX_FERR]    = r_rx_ferr;
        w_status[ST_RX_OVR]     = r_rx_ovr;
    end

    // Read data mux; TXDATA and the reserved slot read as zero
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_STATUS: w_rdata = w_status;
            REG_RXDATA: w_rdata = {24'b0, r_rx_data};
            default:    w_rdata = '0;
        endcase
    end

    // Registered read data: updates on selected reads, zero on foreign accesses
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_dm <= '0;
        end else if (w_rd) begin
            r_dm <= w_rdata;
        end else if (dce && !w_sel) begin
            r_dm <= '0;
        end
    end

    // TX next state: one baud period per bit, back-to-back frames when queued
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_shift_n = w_fifo_dout;
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == BAUD_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = TX_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == BAUD_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == BAUD_LAST) begin
                    w_tx_cnt_n = '0;
                    if (!w_fifo_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_shift_n = w_fifo_dout;
                        w_tx_state_n = TX_START;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    // TX state register; the shift register holds data only and is not reset
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
        end
        r_tx_shift <= w_tx_shift_n;
    end

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // RX next state: verify start at half bit, then sample at full-bit spacing
    always_comb begin
        w_rx_state_n   = r_rx_state;
        w_rx_cnt_n     = r_rx_cnt;
        w_rx_bit_n     = r_rx_bit;
        w_rx_shift_n   = r_rx_shift;
        w_rx_byte_ok   = 1'b0;
        w_rx_frame_bad = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    w_rx_state_n = w_rxs ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BAUD_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {w_rxs, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BAUD_LAST) begin
                    w_rx_cnt_n     = '0;
                    w_rx_state_n   = RX_IDLE;
                    w_rx_byte_ok   = w_rxs;
                    w_rx_frame_bad = !w_rxs;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
        end
        r_rx_shift <= w_rx_shift_n;
    end

    // Receive holding register; a completing byte beats a same-cycle read-clear
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_rx_byte_ok) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
        end else if (w_rx_rd) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky error flags: write-one-to-clear, a new event in the same cycle wins
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_tx_ovf  <= 1'b0;
            r_rx_ferr <= 1'b0;
            r_rx_ovr  <= 1'b0;
        end else begin
            if (w_st_clr && din[ST_TX_OVF])  r_tx_ovf  <= 1'b0;
            if (w_st_clr && din[ST_RX_FERR]) r_rx_ferr <= 1'b0;
            if (w_st_clr && din[ST_RX_OVR])  r_rx_ovr  <= 1'b0;
            if (w_push_req && w_fifo_full)                r_tx_ovf  <= 1'b1;
            if (w_rx_frame_bad)                           r_rx_ferr <= 1'b1;
            if (w_rx_byte_ok && r_rx_valid && !w_rx_rd)   r_rx_ovr  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_uart.sv
// Directed bench for dbus_uart at BAUD_DIV=4: bus decode, TX framing and
// queueing, RX reception and error flags, reset behaviour.
module tb_dbus_uart;

    localparam int          BD   = 4;
    localparam logic [31:0] BASE = 32'h1FD0_F000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_RX = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic        txd;
    logic        rxd;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_b [$];

    always #5 clk = ~clk;

    dbus_uart #(
        .BAUD_DIV   (BD),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .uart_txd    (txd),
        .uart_rxd    (rxd),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        daddr = a; din = d; we = be; dce = 1'b1;
        tick(1);
        dce = 1'b0; we = 4'b0000;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        daddr = a; we = 4'b0000; dce = 1'b1;
        tick(1);
        dce = 1'b0;
        tick(1);
        d = dm;
    endtask

    task automatic wait_tx_low(input string tag);
        int t;
        t = 0;
        while (txd !== 1'b0 && t < 40) begin
            tick(1);
            t++;
        end
        chk(tag, 32'(txd), 32'd0);
    endtask

    // Capture n frames with fixed mid-bit sample points; any gap misaligns them
    task automatic cap_frames(input int n, input string tag);
        logic [9:0] fr;
        wait_tx_low({tag, "_start"});
        tick(2);
        for (int f = 0; f < n; f++) begin
            fr = '0;
            for (int b = 0; b < 10; b++) begin
                fr = {txd, fr[9:1]};
                tick(BD);
            end
            chk($sformatf("%s_frame%0d", tag, f), 32'(fr), 32'({1'b1, exp_b[f], 1'b0}));
        end
        chk({tag, "_idle_after"}, 32'(txd), 32'd1);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[0];
            b = b >> 1;
            tick(BD);
        end
        rxd = stop;
        tick(BD);
        rxd = 1'b1;
        tick(8);
    endtask

    task automatic t_single_tx();
        logic [31:0] d;
        logic [9:0]  sh;
        fork
            begin
                bus_wr(A_TX, 32'h55, 4'b0001);
                tick(12);
                bus_rd(A_ST, d);
                chk("tx55_status_busy", d, 32'h05);
            end
            begin
                wait_tx_low("tx55_start");
                sh = {1'b1, 8'h55, 1'b0};
                for (int k = 0; k < 44; k++) begin
                    chk($sformatf("tx55_txd_c%0d", k), 32'(txd), 32'(sh[0]));
                    if (k % 4 == 3) sh = {1'b1, sh[9:1]};
                    tick(1);
                end
            end
        join
        bus_rd(A_ST, d);
        chk("tx55_status_done", d, 32'h04);
    endtask

    task automatic t_five_tx();
        logic [31:0] d;
        exp_b = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'hFF};
        fork
            begin
                for (int i = 0; i < 5; i++) bus_wr(A_TX, {24'b0, exp_b[i]}, 4'b1111);
            end
            cap_frames(5, "tx5");
        join
        tick(4);
        bus_rd(A_ST, d);
        chk("tx5_status_no_ovf", d, 32'h04);
    endtask

    task automatic t_six_tx();
        logic [31:0] d;
        logic        seen_low;
        exp_b = '{8'hA1, 8'hB2, 8'hC4, 8'hD8, 8'hE7};
        fork
            begin
                for (int i = 0; i < 5; i++) bus_wr(A_TX, {24'b0, exp_b[i]}, 4'b0001);
                bus_wr(A_TX, 32'h0000_0000, 4'b0001);
                bus_rd(A_ST, d);
                chk("tx6_status_full_ovf", d, 32'h13);
                bus_wr(A_ST, 32'h10, 4'b0001);
                bus_rd(A_ST, d);
                chk("tx6_status_ovf_clr", d, 32'h03);
            end
            begin
                cap_frames(5, "tx6");
                seen_low = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    if (txd !== 1'b1) seen_low = 1'b1;
                    tick(1);
                end
                chk("tx6_sixth_dropped", 32'(seen_low), 32'd0);
            end
        join
        bus_rd(A_ST, d);
        chk("tx6_status_done", d, 32'h04);
    endtask

    initial begin
        logic [31:0] d;
        logic        seen_low;
        rst = 1'b1; dce = 1'b0; we = 4'b0000; daddr = '0; din = '0; rxd = 1'b1;
        tick(3);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dm", dm, 32'd0);
        rst = 1'b0;
        tick(1);
        bus_rd(A_ST, d);  chk("rst_status", d, 32'h04);
        bus_rd(A_RX, d);  chk("rst_rxdata", d, 32'h0);
        bus_rd(A_RS, d);  chk("reserved_read", d, 32'h0);

        // Writes without we[0] and writes outside the window do nothing
        bus_wr(A_TX, 32'hAA, 4'b1110);
        bus_wr(32'h1FD0_E000, 32'h77, 4'b1111);
        tick(6);
        chk("nowrite_txd_idle", 32'(txd), 32'd1);
        bus_rd(A_ST, d);  chk("nowrite_status", d, 32'h04);
        bus_rd(32'h1FD1_F004, d);  chk("unselected_read_dm", d, 32'h0);

        t_single_tx();
        t_five_tx();
        t_six_tx();

        // Receive one byte
        rx_send(8'hA5, 1'b1);
        chk("rxA5_irq", 32'(irq), 32'd1);
        bus_rd(A_ST, d);  chk("rxA5_status", d, 32'h0C);
        bus_rd(A_RX, d);  chk("rxA5_data", d, 32'h0000_00A5);
        chk("rxA5_irq_cleared", 32'(irq), 32'd0);

        // Overrun then framing error
        rx_send(8'h3C, 1'b1);
        rx_send(8'h96, 1'b1);
        rx_send(8'h5A, 1'b0);
        bus_rd(A_ST, d);  chk("rxerr_status", d, 32'h6C);
        bus_rd(A_RX, d);  chk("rxerr_data_second", d, 32'h0000_0096);
        bus_wr(A_ST, 32'h60, 4'b0001);
        bus_rd(A_ST, d);  chk("rxerr_cleared", d, 32'h04);

        // One-cycle glitch on the line is ignored
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(12);
        bus_rd(A_ST, d);  chk("rx_glitch_status", d, 32'h04);
        chk("rx_glitch_irq", 32'(irq), 32'd0);

        // Reset in the middle of a data bit, with a second byte still queued
        bus_rd(A_ST, d);
        bus_wr(A_TX, 32'h00, 4'b0001);
        bus_wr(A_TX, 32'h00, 4'b0001);
        wait_tx_low("rst_tx_start");
        tick(10);
        chk("rst_pre_txd_low", 32'(txd), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_dm", dm, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        bus_rd(A_ST, d);  chk("rst_mid_status", d, 32'h04);
        seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (txd !== 1'b1) seen_low = 1'b1;
            tick(1);
        end
        chk("rst_mid_no_more_bits", 32'(seen_low), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", n_chk, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dbus_uart.md
DBUS_UART -- requirements
Module: dbus_uart

Interface
REQ-001 Parameter BAUD_DIV, default 434, meaning cpu_clk_50M cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 Parameter BASE_ADDR, default 32'h1FD0_F000, meaning 16-byte-aligned base of the register window.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning TX FIFO entries; must be a power of two.
REQ-004 cpu_clk_50M  input  1  sole clock; all state changes on its rising edge.
REQ-005 cpu_rst  input  1  reset; synchronous, active-high.
REQ-006 daddr  input  32  byte address from the CPU data port.
REQ-007 dce  input  1  data-port access strobe, one cycle per access.
REQ-008 we  input  4  byte write enables; 4'b0000 with dce=1 means read.
REQ-009 din  input  32  write data.
REQ-010 dm  output  32  read data.
REQ-011 uart_txd  output  1  serial transmit line, idle high.
REQ-012 uart_rxd  input  1  serial receive line, asynchronous.
REQ-013 irq  output  1  level interrupt, equal to rx_valid.

Function
REQ-014 Block SHALL be selected when dce=1 and daddr[31:4]==BASE_ADDR[31:4]; unselected accesses cause no side effects and return dm=0.
REQ-015 Register map by daddr[3:2]: 0=TXDATA (W), 1=STATUS (R/W1C), 2=RXDATA (R), 3=reserved (reads 0, writes ignored).
REQ-016 Read latency SHALL be one cycle, BRAM-compatible: dm for an access at edge N is valid after edge N+1 and holds until the next selected read; writes take effect at edge N.
REQ-017 STATUS bits: [0] tx_busy, [1] fifo_full, [2] fifo_empty, [3] rx_valid, [4] tx_overflow, [5] rx_frame_err, [6] rx_overrun; [31:7]=0.
REQ-018 Write to TXDATA with we[0]=1 SHALL push din[7:0] if the FIFO is not full; if full, data is dropped and tx_overflow set; we[0]=0 ignored.
REQ-019 Write to STATUS with we[0]=1 SHALL clear each sticky bit [6:4] whose din bit is 1.
REQ-020 Fullness is evaluated before the edge: push plus simultaneous TX pop when full SHALL drop the push; when not full, push and pop in one cycle leave count unchanged.
REQ-021 TX FSM states IDLE, START, DATA, STOP; each bit lasts exactly BAUD_DIV cycles; data sent LSB first; uart_txd=1 in IDLE and STOP.
REQ-022 IDLE->START on the edge after FIFO becomes non-empty (pop at that edge); STOP->START directly with no idle bit if FIFO non-empty, else STOP->IDLE.
REQ-023 tx_busy SHALL be 1 in any state other than IDLE.
REQ-024 RX: uart_rxd through a 2-flop synchronizer; RX FSM IDLE, START, DATA, STOP.
REQ-025 RX IDLE->START on synchronized falling edge; after BAUD_DIV/2 cycles line sampled: 0 -> DATA, 1 -> IDLE (glitch, no flags).
REQ-026 Eight data bits sampled every BAUD_DIV cycles thereafter, LSB first; stop bit sampled BAUD_DIV later.
REQ-027 Stop=1: byte loaded to rx_data, rx_valid set; if rx_valid already 1, rx_data overwritten and rx_overrun set. Stop=0: byte discarded, rx_frame_err set.
REQ-028 Selected read of RXDATA SHALL return {24'b0, rx_data} and clear rx_valid at the access edge; if a new byte completes in the same cycle, new byte wins, rx_valid stays 1, no overrun.

Reset
REQ-029 While cpu_rst=1: dm=0, uart_txd=1, irq=0, FIFO empty, both FSMs IDLE, baud counters 0, rx_data=0, all sticky bits 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; uart_txd is 1 from the edge where reset is sampled and no partial byte is reported.

Structure
REQ-031 Shared package holds register offsets, STATUS bit indices, and TX/RX FSM state encodings.
REQ-032 One sub-module, dbus_uart_fifo: synchronous FIFO_DEPTH x 8 with push, pop, full, empty; all else in dbus_uart.

Verification (BAUD_DIV=4)
REQ-033 Write 32'h55 to TXDATA -> uart_txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; tx_busy=1 throughout, then 0.
REQ-034 Five back-to-back TXDATA writes while idle -> all five bytes sent with no idle gap (first pops immediately, four queue, none dropped); tx_overflow=0.
REQ-035 Six TXDATA writes while idle -> sixth dropped, STATUS reads 0x13 (busy, full, overflow); writing STATUS din=0x10 clears bit 4.
REQ-036 Drive 8'hA5 on uart_rxd with valid stop -> irq=1, STATUS[3]=1; RXDATA read returns 32'h0000_00A5 one cycle later and irq falls.
REQ-037 Drive two bytes without reading, then a frame with stop=0 -> rx_overrun=1, rx_data holds second byte, rx_frame_err=1.
REQ-038 Assert cpu_rst mid-TX-data-bit -> uart_txd=1 next edge, STATUS reads 0x04, no further bits emitted.
